// File: rtl/mem_burst_ram.sv
// Single-port RAM with byte write enables, READ_LATENCY-deep read pipeline and wrapping read bursts.
// Define MEM_PARITY_EN to add per-byte even parity storage, Err_inj corruption and Parity_err reporting.
module mem_burst_ram #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int BURST_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      wen,
    input  logic [ADDR_WIDTH-1:0]     Addr,
    input  logic [DATA_WIDTH-1:0]     Data_in,
    input  logic [DATA_WIDTH/8-1:0]   Byte_en,
    input  logic [BURST_WIDTH-1:0]    Burst_len,
    input  logic                      Err_inj,
    output logic [DATA_WIDTH-1:0]     Data_out,
    output logic                      Valid,
    output logic                      Last,
    output logic                      Busy,
    output logic                      Parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_n;
    logic [BURST_WIDTH-1:0]  cnt, cnt_n;
    logic                    issue, issue_last, wr;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    rd_perr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cur_addr <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_addr_n;
            cnt      <= cnt_n;
        end
    end

    // cnt holds the number of beats still to issue after the current one.
    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        cnt_n      = cnt;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = cur_addr;
        wr         = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (wen) begin
                        wr = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = Addr;
                        issue_last = (Burst_len == '0);
                        cur_addr_n = Addr;
                        cnt_n      = Burst_len;
                        if (Burst_len != '0) state_n = BURST;
                    end
                end
            end
            BURST: begin
                issue      = 1'b1;
                issue_addr = cur_addr + ADDR_WIDTH'(1);
                cur_addr_n = issue_addr;
                cnt_n      = cnt - BURST_WIDTH'(1);
                if (cnt == BURST_WIDTH'(1)) begin
                    issue_last = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state == BURST);

    always_ff @(posedge clk) begin
        if (wr) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (Byte_en[b]) mem[Addr][8*b +: 8] <= Data_in[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[issue_addr];

`ifdef MEM_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (Byte_en[b]) par_mem[Addr][b] <= (^Data_in[8*b +: 8]) ^ Err_inj;
            end
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if ((^rd_word[8*b +: 8]) != par_mem[issue_addr][b]) rd_perr = 1'b1;
        end
    end
`else
    logic unused_err_inj;
    assign unused_err_inj = Err_inj;
    assign rd_perr        = 1'b0;
`endif

    logic [READ_LATENCY-1:0]                 vld_pipe, lst_pipe, per_pipe;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;

    // Data stages only advance with a valid beat, so the output stage holds its last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
            per_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            lst_pipe[0] <= issue & issue_last;
            per_pipe[0] <= issue & rd_perr;
            if (issue) dat_pipe[0] <= rd_word;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                lst_pipe[i] <= lst_pipe[i-1];
                per_pipe[i] <= per_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign Data_out   = dat_pipe[READ_LATENCY-1];
    assign Valid      = vld_pipe[READ_LATENCY-1];
    assign Last       = lst_pipe[READ_LATENCY-1];
    assign Parity_err = per_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_burst_ram.sv
// Scoreboard bench for mem_burst_ram: two instances (READ_LATENCY 1 and 3) share one stimulus stream.
module tb_mem_burst_ram;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b0, wen = 1'b0, err_inj = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  be = '0;
    logic [2:0]  blen = '0;

    logic [31:0] d1, d3;
    logic        v1, l1, b1, p1, v3, l3, b3, p3;

    mem_burst_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .BURST_WIDTH(3)) dut1 (
        .clk(clk), .rstn(rstn), .en(en), .wen(wen), .Addr(addr), .Data_in(din),
        .Byte_en(be), .Burst_len(blen), .Err_inj(err_inj),
        .Data_out(d1), .Valid(v1), .Last(l1), .Busy(b1), .Parity_err(p1));

    mem_burst_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(3), .BURST_WIDTH(3)) dut3 (
        .clk(clk), .rstn(rstn), .en(en), .wen(wen), .Addr(addr), .Data_in(din),
        .Byte_en(be), .Burst_len(blen), .Err_inj(err_inj),
        .Data_out(d3), .Valid(v3), .Last(l3), .Busy(b3), .Parity_err(p3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        perr;
        int          cyc;
    } beat_t;

    beat_t q1[$];
    beat_t q3[$];
    beat_t e1, e3;

    logic [31:0] model [16];
    logic [3:0]  bad   [16];

    always @(negedge clk) begin
        if (rstn) begin
            if (v1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL l1_unexpected_valid: got Valid=1 data=%h, required Valid=0", d1);
                end else begin
                    e1 = q1.pop_front();
                    if ({d1, l1, p1} !== {e1.data, e1.last, e1.perr} || cyc != e1.cyc) begin
                        errors++;
                        $display("FAIL l1_beat: got data=%h last=%b perr=%b cycle=%0d, required data=%h last=%b perr=%b cycle=%0d",
                                 d1, l1, p1, cyc, e1.data, e1.last, e1.perr, e1.cyc);
                    end
                end
            end else if (l1 || p1) begin
                checks++;
                errors++;
                $display("FAIL l1_flags_without_valid: got Last=%b Parity_err=%b, required 0 0", l1, p1);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (v3) begin
                checks++;
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL l3_unexpected_valid: got Valid=1 data=%h, required Valid=0", d3);
                end else begin
                    e3 = q3.pop_front();
                    if ({d3, l3, p3} !== {e3.data, e3.last, e3.perr} || cyc != e3.cyc) begin
                        errors++;
                        $display("FAIL l3_beat: got data=%h last=%b perr=%b cycle=%0d, required data=%h last=%b perr=%b cycle=%0d",
                                 d3, l3, p3, cyc, e3.data, e3.last, e3.perr, e3.cyc);
                    end
                end
            end else if (l3 || p3) begin
                checks++;
                errors++;
                $display("FAIL l3_flags_without_valid: got Last=%b Parity_err=%b, required 0 0", l3, p3);
            end
        end
    end

    function automatic logic exp_perr(input int a);
`ifdef MEM_PARITY_EN
        return |bad[a];
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] bmask, input logic ei);
        for (int k = 0; k < 4; k++) begin
            if (bmask[k]) begin
                model[a][8*k +: 8] = d[8*k +: 8];
                bad[a][k]          = ei;
            end
        end
        addr = 4'(a); din = d; be = bmask; err_inj = ei; wen = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; wen = 1'b0; err_inj = 1'b0;
    endtask

    task automatic do_read(input int a, input int n);
        beat_t b;
        for (int j = 0; j <= n; j++) begin
            b.data = model[(a + j) % 16];
            b.last = (j == n);
            b.perr = exp_perr((a + j) % 16);
            b.cyc  = cyc + j + 1;
            q1.push_back(b);
            b.cyc  = cyc + j + 3;
            q3.push_back(b);
        end
        addr = 4'(a); blen = 3'(n); wen = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (q1.size() != 0 || q3.size() != 0); i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d beats outstanding, required 0/0", q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({d1, v1, l1, b1, p1} !== 36'h0) begin
            errors++;
            $display("FAIL reset_l1: got data=%h V=%b L=%b B=%b P=%b, required all 0", d1, v1, l1, b1, p1);
        end
        checks++;
        if ({d3, v3, l3, b3, p3} !== 36'h0) begin
            errors++;
            $display("FAIL reset_l3: got data=%h V=%b L=%b B=%b P=%b, required all 0", d3, v3, l3, b3, p3);
        end
        @(posedge clk); @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) do_write(i, 32'hA500_0000 | 32'(i), 4'hF, 1'b0);
    endtask

    task automatic test_single_rw();
        do_write(3, 32'hDEADBEEF, 4'hF, 1'b0);
        do_read(3, 0);
        checks++;
        if ({b1, b3} !== 2'b00) begin
            errors++;
            $display("FAIL single_busy: got Busy=%b%b, required 00", b1, b3);
        end
        wait_drain();
        checks++;
        if (d1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_data: got %h, required deadbeef", d1);
        end
    endtask

    task automatic test_byte_enable();
        do_write(5, 32'h11223344, 4'hF, 1'b0);
        do_write(5, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_read(5, 0);
        wait_drain();
        checks++;
        if (d1 !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_enable: got %h, required 11bb33dd", d1);
        end
    endtask

    task automatic test_burst_wrap();
        do_write(14, 32'hE, 4'hF, 1'b0);
        do_write(15, 32'hF, 4'hF, 1'b0);
        do_write(0,  32'h0, 4'hF, 1'b0);
        do_write(1,  32'h1, 4'hF, 1'b0);
        do_read(14, 3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({b1, b3} !== 2'b11) begin
                errors++;
                $display("FAIL burst_busy_high: got Busy=%b%b in burst cycle %0d, required 11", b1, b3, k);
            end
            addr = (k == 1) ? 4'd14 : 4'd9;
            din  = 32'h00000BAD;
            be   = 4'hF;
            blen = 3'd2;
            wen  = (k == 1);
            en   = 1'b1;
            @(posedge clk); #1;
        end
        en = 1'b0; wen = 1'b0;
        checks++;
        if ({b1, b3} !== 2'b00) begin
            errors++;
            $display("FAIL burst_busy_low: got Busy=%b%b after final beat, required 00", b1, b3);
        end
        wait_drain();
        do_read(14, 0);
        wait_drain();
        checks++;
        if (d1 !== 32'hE) begin
            errors++;
            $display("FAIL busy_write_ignored: got %h, required 0000000e", d1);
        end
    endtask

    task automatic test_back_to_back();
        do_read(0, 1);
        @(posedge clk); #1;
        checks++;
        if ({b1, b3} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_busy_fall: got Busy=%b%b, required 00", b1, b3);
        end
        do_read(14, 1);
        wait_drain();
    endtask

    task automatic test_latency3();
        do_write(2, 32'h22220002, 4'hF, 1'b0);
        do_write(3, 32'h33330003, 4'hF, 1'b0);
        do_read(2, 1);
        wait_drain();
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (v3 !== 1'b0 || d3 !== 32'h33330003) begin
                errors++;
                $display("FAIL l3_hold: got Valid=%b data=%h, required Valid=0 data=33330003", v3, d3);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_read(0, 7);
        @(posedge clk); #1;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({d1, v1, l1, b1, p1} !== 36'h0 || {d3, v3, l3, b3, p3} !== 36'h0) begin
            errors++;
            $display("FAIL midburst_reset: got l1 data=%h V=%b L=%b B=%b, l3 data=%h V=%b L=%b B=%b, required all 0",
                     d1, v1, l1, b1, d3, v3, l3, b3);
        end
        q1.delete();
        q3.delete();
        @(posedge clk); @(posedge clk); #2 rstn = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            checks++;
            if ({v1, v3, b1, b3} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_quiet: got Valid=%b%b Busy=%b%b, required 0000", v1, v3, b1, b3);
            end
        end
        do_read(0, 7);
        wait_drain();
        do_read(3, 0);
        wait_drain();
        checks++;
        if (d1 !== 32'h33330003) begin
            errors++;
            $display("FAIL retained_after_reset: got %h, required 33330003", d1);
        end
    endtask

    task automatic test_parity();
        do_write(7, 32'h01020304, 4'hF, 1'b0);
        do_write(7, 32'h01020304, 4'b0001, 1'b1);
        do_read(7, 0);
        wait_drain();
        do_write(7, 32'h01020304, 4'b0001, 1'b0);
        do_read(7, 0);
        wait_drain();
        checks++;
        if (d1 !== 32'h01020304) begin
            errors++;
            $display("FAIL parity_data: got %h, required 01020304", d1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_rw();
        test_byte_enable();
        test_burst_wrap();
        test_back_to_back();
        test_latency3();
        test_reset_mid_burst();
        test_parity();
        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_ram.md
Name: mem_burst_ram

Overview:
- Parametrised successor to the team's single-port RAM (en/wen/Addr/Data_in/Data_out/Valid).
- Adds per-byte write enables, a configurable read-pipeline latency and multi-beat read bursts with address auto-increment and wrap.
- Sits behind the memory interface as the DUT for the class-based environment; drives Valid, Last and Busy back to the bench.

Parameters:
ADDR_WIDTH, 4, word-address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, data width in bits; must be a multiple of 8; BYTES = DATA_WIDTH/8
READ_LATENCY, 1, cycles from address issue to Valid data; legal range 1..4
BURST_WIDTH, 3, width of Burst_len; maximum burst = 2**BURST_WIDTH beats

Ports:
clk  input  1  clock; all logic on the rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  request strobe; sampled only while Busy=0
wen  input  1  1=write, 0=read burst; qualified by en
Addr  input  ADDR_WIDTH  word start address
Data_in  input  DATA_WIDTH  write data
Byte_en  input  BYTES  per-byte write mask; bit i covers Data_in[8i+7:8i]
Burst_len  input  BURST_WIDTH  read beats minus one (0 = single read)
Err_inj  input  1  parity error injection on write; used only with MEM_PARITY_EN
Data_out  output  DATA_WIDTH  read data
Valid  output  1  Data_out holds a read beat this cycle
Last  output  1  final beat of the burst; only ever high with Valid
Busy  output  1  burst in progress; new requests ignored
Parity_err  output  1  parity mismatch on the current Valid beat

Behaviour:
- Reset (rstn=0, asynchronous): Data_out=0, Valid=0, Last=0, Busy=0, Parity_err=0. FSM goes to IDLE and the read pipeline flushes. Memory array is not cleared; contents are retained.
- FSM states: IDLE and BURST.
- IDLE, en=1, wen=1: single-cycle write. For each byte i with Byte_en[i]=1, mem[Addr] byte i gets Data_in byte i; other bytes are unchanged. No Valid is produced. FSM stays in IDLE.
- IDLE, en=1, wen=0: issue beat 0 at Addr and load beat counter = Burst_len.
  - Burst_len=0: stay in IDLE; Busy never asserts.
  - Burst_len>0: go to BURST; Busy=1 from the next cycle.
- BURST: one beat issued per cycle at (previous address + 1) mod DEPTH, so 15 wraps to 0 when DEPTH=16. Counter decrements each beat. When the final beat is issued, go to IDLE and drop Busy the following cycle. en is ignored throughout BURST.
- Latency: a beat issued at cycle N has Valid=1 at cycle N+READ_LATENCY with Data_out = mem[addr] as of issue.
  - Beats are delivered back-to-back with no gaps.
  - Last=1 on the beat whose counter was 0.
- Ordering: a read issued the cycle after a write to the same address returns the new data. Write-then-read in one request is impossible because wen selects one operation.
- Data_out holds its last value while Valid=0.
- A new request may be accepted in the cycle Busy falls. Its beats then follow the previous burst's tail in the pipeline with no overlap.
- Reset mid-burst: burst aborts and in-flight beats are discarded. No Valid after rstn rises until a new read is issued.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each byte lane stores an even-parity bit, written together with its byte under Byte_en.
  - Err_inj=1 on a write inverts the stored parity bits of the enabled lanes.
  - On each Valid beat, Parity_err=1 if any lane's parity mismatches. It is pipelined alongside Data_out.
- Undefined:
  - No parity storage.
  - Err_inj is ignored.
  - Parity_err is tied 0.
- Port list is identical in both builds.

Test Plan:
- Reset, then write 0xDEADBEEF at Addr 3 with Byte_en=4'hF, then single read at Addr 3 (READ_LATENCY=1) -> Valid, Last and Data_out=0xDEADBEEF, one cycle after issue.
- Mem[5]=0x11223344, then write 0xAABBCCDD at Addr 5 with Byte_en=4'b0101, then read -> Data_out=0x11BB33DD.
- Write mem[14]=0xE, mem[15]=0xF, mem[0]=0x0, mem[1]=0x1; read burst at Addr 14 with Burst_len=3 (DEPTH=16) -> 4 consecutive Valid beats 0xE, 0xF, 0x0, 0x1; Last on 4th only; Busy high 3 cycles; en pulses during Busy ignored.
- READ_LATENCY=3, Burst_len=1 at Addr 2 -> Valid at issue+3 and issue+4, no gap; Data_out held afterwards.
- Start burst Burst_len=7, assert rstn=0 after 2 beats -> all outputs 0 immediately; no further Valid after rstn release; mem contents intact on re-read.
- With MEM_PARITY_EN: write 0x01020304 at Addr 7 with Err_inj=1, Byte_en=4'b0001, then read -> Data_out=0x01020304, Parity_err=1. Rewrite with Err_inj=0 -> Parity_err=0.
